// File: rtl/package_project_typedefs.sv
// Shared pipeline typedefs: per-stage signal bundles, forwarding selects and
// the hazard metadata record carried from EX through WB.
package package_project_typedefs;

  typedef struct packed {
    logic [4:0] ID;
    logic [4:0] EX;
    logic [4:0] MEM;
    logic [4:0] WB;
  } PipeLineSignal_5;

  typedef struct packed {
    logic ID;
    logic EX;
    logic MEM;
    logic WB;
  } PipeLineSignal_1;

  typedef enum logic [1:0] {
    NO_FWD,
    EX_ID_FWD,
    MEM_ID_FWD,
    WB_ID_FWD
  } ForwardingControl;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wr_en;
    logic       is_load;
  } HazardStageInfo;

  localparam HazardStageInfo HAZARD_BUBBLE = '0;

  // A load still in flight in stage s whose result a used ID source needs.
  function automatic logic load_use_match(input HazardStageInfo s,
                                          input logic [4:0]     rs,
                                          input logic           used);
    return s.is_load & s.wr_en & (s.rd != 5'd0) & used & (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of hazard metadata; bubble insertion overrides advance.
import package_project_typedefs::*;

module hazard_stage_reg (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_bubble,
  input  logic           advance,
  input  HazardStageInfo d,
  output HazardStageInfo q
);

  // NOTE: state registers use non-blocking assignments and a synchronous
  // reset, so every stage updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= HAZARD_BUBBLE;
    end else if (load_bubble) begin
      q <= HAZARD_BUBBLE;
    end else if (advance) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_tracker.sv
// Tracks rd/rs1/rs2/wr_en/is_load from ID to WB, raises load-use stalls that
// forwarding cannot cover, and counts stall cycles.
import package_project_typedefs::*;

module pipeline_hazard_tracker #(
  parameter int LOAD_LATENCY = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rd_addr,
  input  logic [4:0]             id_rs1_addr,
  input  logic [4:0]             id_rs2_addr,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic                   id_reg_wr_en,
  input  logic                   id_is_load,
  input  logic                   flush_id_ex,
  output PipeLineSignal_5        reg_file_wr_addr,
  output PipeLineSignal_5        reg_file_rd_addr_1,
  output PipeLineSignal_5        reg_file_rd_addr_2,
  output PipeLineSignal_1        reg_file_wr_en_cntrl,
  output logic                   load_use_stall,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  HazardStageInfo id_info, ex_q, mem_q, wb_q;
  logic           ex_hit, mem_hit, ex_bubble;

  assign id_info = '{
    rd:      id_rd_addr,
    rs1:     id_rs1_addr,
    rs2:     id_rs2_addr,
    wr_en:   id_valid & id_reg_wr_en,
    is_load: id_valid & id_is_load
  };

  assign ex_hit  = load_use_match(ex_q, id_rs1_addr, id_rs1_used)
                 | load_use_match(ex_q, id_rs2_addr, id_rs2_used);
  // With a two-stage load, data is also unavailable while the load sits in MEM.
  assign mem_hit = (LOAD_LATENCY >= 2)
                 & (load_use_match(mem_q, id_rs1_addr, id_rs1_used)
                  | load_use_match(mem_q, id_rs2_addr, id_rs2_used));

  assign load_use_stall = id_valid & (ex_hit | mem_hit) & ~flush_id_ex;
  assign ex_bubble      = load_use_stall | flush_id_ex;

  hazard_stage_reg u_ex (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (ex_bubble),
    .advance     (1'b1),
    .d           (id_info),
    .q           (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (1'b0),
    .advance     (1'b1),
    .d           (ex_q),
    .q           (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (1'b0),
    .advance     (1'b1),
    .d           (mem_q),
    .q           (wb_q)
  );

  always_comb begin
    reg_file_wr_addr     = '{ID: id_info.rd,    EX: ex_q.rd,    MEM: mem_q.rd,    WB: wb_q.rd};
    reg_file_rd_addr_1   = '{ID: id_info.rs1,   EX: ex_q.rs1,   MEM: mem_q.rs1,   WB: wb_q.rs1};
    reg_file_rd_addr_2   = '{ID: id_info.rs2,   EX: ex_q.rs2,   MEM: mem_q.rs2,   WB: wb_q.rs2};
    reg_file_wr_en_cntrl = '{ID: id_info.wr_en, EX: ex_q.wr_en, MEM: mem_q.wr_en, WB: wb_q.wr_en};
  end

  // Saturating counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (load_use_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// Bench for pipeline_hazard_tracker: three configurations share stimulus and are
// compared every cycle against a stage-array model, plus directed vectors.
import package_project_typedefs::*;

module tb_pipeline_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_rs1_used, id_rs2_used, id_reg_wr_en, id_is_load, flush_id_ex;
  logic [4:0] id_rd_addr, id_rs1_addr, id_rs2_addr;

  PipeLineSignal_5 wa0, r10, r20, wa1, r11, r21, wa2, r12, r22;
  PipeLineSignal_1 we0, we1, we2;
  logic            st0, st1, st2;
  logic [15:0]     cnt0, cnt1;
  logic [1:0]      cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_tracker #(.LOAD_LATENCY(1), .STALL_CNT_W(16)) u_l1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd_addr(id_rd_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load),
    .flush_id_ex(flush_id_ex), .reg_file_wr_addr(wa0), .reg_file_rd_addr_1(r10),
    .reg_file_rd_addr_2(r20), .reg_file_wr_en_cntrl(we0), .load_use_stall(st0),
    .stall_cycles(cnt0));

  pipeline_hazard_tracker #(.LOAD_LATENCY(2), .STALL_CNT_W(16)) u_l2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd_addr(id_rd_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load),
    .flush_id_ex(flush_id_ex), .reg_file_wr_addr(wa1), .reg_file_rd_addr_1(r11),
    .reg_file_rd_addr_2(r21), .reg_file_wr_en_cntrl(we1), .load_use_stall(st1),
    .stall_cycles(cnt1));

  pipeline_hazard_tracker #(.LOAD_LATENCY(1), .STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd_addr(id_rd_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load),
    .flush_id_ex(flush_id_ex), .reg_file_wr_addr(wa2), .reg_file_rd_addr_1(r12),
    .reg_file_rd_addr_2(r22), .reg_file_wr_en_cntrl(we2), .load_use_stall(st2),
    .stall_cycles(cnt2));

  // Reference model: per configuration, an array of in-flight instructions
  // indexed 0=EX, 1=MEM, 2=WB, and a plain integer stall count.
  typedef struct {
    logic [4:0] rd, rs1, rs2;
    logic       wr_en, is_load;
  } stage_t;

  stage_t      pipe [3][3];
  int unsigned mcnt [3];
  int          lat  [3] = '{1, 2, 1};
  int unsigned cmax [3] = '{65535, 65535, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A load is "not yet forwardable" while it is among the first lat stages.
  function automatic logic model_stall(input int i);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < lat[i]; k++) begin
      stage_t s;
      s = pipe[i][k];
      if (s.is_load && s.wr_en && s.rd != 5'd0 &&
          ((id_rs1_used && s.rd == id_rs1_addr) || (id_rs2_used && s.rd == id_rs2_addr)))
        hit = 1'b1;
    end
    return id_valid && hit && !flush_id_ex;
  endfunction

  task automatic model_clock();
    for (int i = 0; i < 3; i++) begin
      logic   st;
      stage_t bub;
      bub = '{default: '0};
      st  = model_stall(i);
      if (rst) begin
        for (int k = 0; k < 3; k++) pipe[i][k] = bub;
        mcnt[i] = 0;
      end else begin
        pipe[i][2] = pipe[i][1];
        pipe[i][1] = pipe[i][0];
        if (st || flush_id_ex) pipe[i][0] = bub;
        else pipe[i][0] = '{rd: id_rd_addr, rs1: id_rs1_addr, rs2: id_rs2_addr,
                            wr_en: id_valid && id_reg_wr_en, is_load: id_valid && id_is_load};
        if (st && mcnt[i] < cmax[i]) mcnt[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      PipeLineSignal_5 e_wa, e_r1, e_r2, a_wa, a_r1, a_r2;
      PipeLineSignal_1 e_we, a_we;
      logic            a_st;
      logic [31:0]     a_cnt;
      e_wa = '{ID: id_rd_addr,  EX: pipe[i][0].rd,  MEM: pipe[i][1].rd,  WB: pipe[i][2].rd};
      e_r1 = '{ID: id_rs1_addr, EX: pipe[i][0].rs1, MEM: pipe[i][1].rs1, WB: pipe[i][2].rs1};
      e_r2 = '{ID: id_rs2_addr, EX: pipe[i][0].rs2, MEM: pipe[i][1].rs2, WB: pipe[i][2].rs2};
      e_we = '{ID: id_valid & id_reg_wr_en, EX: pipe[i][0].wr_en,
               MEM: pipe[i][1].wr_en, WB: pipe[i][2].wr_en};
      case (i)
        0:       begin a_wa = wa0; a_r1 = r10; a_r2 = r20; a_we = we0; a_st = st0; a_cnt = 32'(cnt0); end
        1:       begin a_wa = wa1; a_r1 = r11; a_r2 = r21; a_we = we1; a_st = st1; a_cnt = 32'(cnt1); end
        default: begin a_wa = wa2; a_r1 = r12; a_r2 = r22; a_we = we2; a_st = st2; a_cnt = 32'(cnt2); end
      endcase
      check($sformatf("wr_addr[%0d]", i), 32'(a_wa), 32'(e_wa));
      check($sformatf("rd_addr_1[%0d]", i), 32'(a_r1), 32'(e_r1));
      check($sformatf("rd_addr_2[%0d]", i), 32'(a_r2), 32'(e_r2));
      check($sformatf("wr_en[%0d]", i), 32'(a_we), 32'(e_we));
      check($sformatf("stall[%0d]", i), 32'(a_st), 32'(model_stall(i)));
      check($sformatf("stall_cycles[%0d]", i), a_cnt, mcnt[i]);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2, input logic we,
                       input logic ld, input logic fl);
    rst = r; id_valid = v; id_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_rs1_used = u1; id_rs2_used = u2; id_reg_wr_en = we; id_is_load = ld; flush_id_ex = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // Directed vectors: ID inputs, then hand-derived stall flags, stage rd values
  // and counters for the LOAD_LATENCY=1 (suffix 1) and =2 (suffix 2) instances.
  typedef struct {
    logic       v;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, we, ld, fl;
    logic       s1, s2;
    logic [4:0] ex1, mem1, wb1, ex2, mem2, wb2;
    int         c1, c2;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         v  rd rs1 rs2 u1 u2 we ld fl  s1 s2 ex1 mem1 wb1 ex2 mem2 wb2 c1 c2
    tbl[0]  = '{1, 5, 1, 2, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 0, 0, 5, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 5, 0, 0, 5, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 5, 0, 0, 5, 0, 0};
    tbl[4]  = '{1, 7, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 3, 7, 0, 1, 0, 1, 0, 0,  1, 1, 7, 0, 0, 7, 0, 0, 0, 0};
    tbl[6]  = '{1, 3, 7, 0, 1, 0, 1, 0, 0,  0, 1, 0, 7, 0, 0, 7, 0, 1, 1};
    tbl[7]  = '{1, 3, 7, 0, 1, 0, 1, 0, 0,  0, 0, 3, 0, 7, 0, 0, 7, 1, 2};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 3, 0, 3, 0, 0, 1, 2};
    tbl[9]  = '{1, 7, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 3, 3, 0, 3, 0, 1, 2};
    tbl[10] = '{1, 3, 7, 0, 0, 0, 1, 0, 0,  0, 0, 7, 0, 3, 7, 0, 3, 1, 2};
    tbl[11] = '{1, 3, 7, 0, 0, 0, 1, 0, 0,  0, 0, 3, 7, 0, 3, 7, 0, 1, 2};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 3, 3, 7, 3, 3, 7, 1, 2};
    tbl[13] = '{1, 4, 0, 0, 1, 1, 1, 0, 0,  0, 0, 0, 3, 3, 0, 3, 3, 1, 2};
    tbl[14] = '{1, 9, 0, 0, 0, 0, 1, 1, 0,  0, 0, 4, 0, 3, 4, 0, 3, 1, 2};
    tbl[15] = '{1, 6, 9, 0, 1, 0, 1, 0, 1,  0, 0, 9, 4, 0, 9, 4, 0, 1, 2};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 9, 4, 0, 9, 4, 1, 2};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 9, 0, 0, 9, 1, 2};

    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tick();
    tick();

    for (int k = 0; k < 18; k++) begin
      vec_t t;
      t = tbl[k];
      drive(0, t.v, t.rd, t.rs1, t.rs2, t.u1, t.u2, t.we, t.ld, t.fl);
      #2;
      check_all();
      check($sformatf("v%0d_stall_l1", k), 32'(st0), 32'(t.s1));
      check($sformatf("v%0d_stall_l2", k), 32'(st1), 32'(t.s2));
      check($sformatf("v%0d_stages_l1", k), {17'd0, wa0.EX, wa0.MEM, wa0.WB}, {17'd0, t.ex1, t.mem1, t.wb1});
      check($sformatf("v%0d_stages_l2", k), {17'd0, wa1.EX, wa1.MEM, wa1.WB}, {17'd0, t.ex2, t.mem2, t.wb2});
      check($sformatf("v%0d_cnt_l1", k), 32'(cnt0), t.c1);
      check($sformatf("v%0d_cnt_l2", k), 32'(cnt1), t.c2);
      tick();
    end

    // A load that reads its own destination stalls every other cycle on
    // LOAD_LATENCY=1: ten cycles give five stalls.
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 7, 7, 0, 1, 0, 1, 1, 0);
      #2;
      check_all();
      tick();
    end
    drive(0, 1, 7, 7, 0, 1, 0, 1, 1, 0);
    #2;
    check_all();
    check("sat_idle_stall", 32'(st0), 32'd0);
    check("sat_cnt_wide", 32'(cnt0), 32'd6);
    check("sat_cnt_narrow", 32'(cnt2), 32'd3);
    tick();

    // Reset arriving in the middle of a stall.
    drive(1, 1, 7, 7, 0, 1, 0, 1, 1, 0);
    #2;
    check_all();
    check("rst_mid_stall_active", 32'(st0), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_all();
    check("rst_stages_zero", {17'd0, wa0.EX, wa0.MEM, wa0.WB}, 32'd0);
    check("rst_wr_en_zero", {29'd0, we0.EX, we0.MEM, we0.WB}, 32'd0);
    check("rst_cnt_zero", 32'(cnt0) + 32'(cnt2), 32'd0);
    check("rst_stall_zero", 32'(st0), 32'd0);
    tick();

    // Random traffic on a small register range so hazards are frequent.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      #2;
      check_all();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
